decimacao_2x: RTL and testbench
===============================

DECIMACAO_2X -- requirements
Module: decimacao_2x

Interface
REQ-001 SHALL have parameter IMG_W, default 160: input frame width in pixels; must be even and at least 2.
REQ-002 SHALL have parameter IMG_H, default 120: input frame height in lines; must be even and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a frame when sampled high in IDLE.
REQ-006 SHALL have port in_pixel, input, 8 bits: raster-order source pixel.
REQ-007 SHALL have port in_valid, input, 1 bit: in_pixel is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_pixel this cycle.
REQ-009 SHALL have port out_pixel, output, 8 bits: reduced pixel, in raster order.
REQ-010 SHALL have port out_valid, output, 1 bit: out_pixel is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: sink consumes out_pixel this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-014 SHALL be the 2x downscale counterpart of replication: IMG_W x IMG_H in -> (IMG_W/2) x (IMG_H/2) out.
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN on acceptance of last pixel (row IMG_H-1, col IMG_W-1); DRAIN -> DONE when output register empty; DONE -> IDLE after one cycle.
REQ-016 SHALL ignore start outside IDLE; at IDLE->RUN, clear col/row counters to 0.
REQ-017 SHALL hold in_ready at 0 in IDLE, DRAIN and DONE; in RUN, in_ready = !out_valid || out_ready.
REQ-018 SHALL accept a pixel only when in_valid && in_ready; col wraps IMG_W-1 -> 0 and increments row.
REQ-019 SHALL use a one-entry output register: loaded with 1-cycle latency after the qualifying accept; out_valid clears on out_ready unless reloaded that same cycle.
REQ-020 SHALL hold out_pixel and out_valid stable while out_valid && !out_ready; no output is lost or duplicated.
REQ-021 SHALL, in decimation mode, emit the pixel accepted at even row and even col and discard all others.
REQ-022 SHALL assert done for exactly one cycle in DONE; exactly (IMG_W/2)*(IMG_H/2) outputs per frame.

Reset
REQ-023 SHALL, on reset, force IDLE, counters 0, in_ready=0, out_valid=0, out_pixel=0, busy=0, done=0, independent of clk.
REQ-024 SHALL discard a partial frame on reset mid-operation; the next frame requires a new start.

Configuration
REQ-025 SHALL, with macro DECIMACAO_MEDIA_EN defined, output the 2x2 block average instead of the top-left sample.
REQ-026 SHALL, in average mode: on even rows, store 9-bit horizontal pair sums in a line buffer indexed col/2; on odd rows, add the pair to the stored sum (10 bits) and output sum>>2, truncated, with the same 1-cycle latency on the odd-row/odd-col accept.
REQ-027 SHALL, without DECIMACAO_MEDIA_EN, contain no line buffer and no adders.

Structure
REQ-028 SHALL place the FSM state encodings and the default IMG_W/IMG_H constants in shared package decimacao_pkg.
REQ-029 SHALL place the line buffer in sub-module linha_buffer: IMG_W/2 entries x 9 bits, 1 write port, 1 read port, instantiated only under DECIMACAO_MEDIA_EN.

Verification
REQ-030 SHALL cover: IMG_W=IMG_H=4, ramp 0..15, out_ready=1, decimation -> outputs 0,2,8,10, then a single done pulse.
REQ-031 SHALL cover: same stimulus with DECIMACAO_MEDIA_EN -> outputs 2,4,10,12.
REQ-032 SHALL cover: all-255 frame with DECIMACAO_MEDIA_EN -> every output 255 (sum 1020>>2).
REQ-033 SHALL cover: out_ready held low for 5 cycles with a pending output -> in_ready=0, out_pixel stable, sequence intact after release.
REQ-034 SHALL cover: reset asserted after 6 accepts -> all outputs 0 immediately; a new start with ramp 0..15 -> 0,2,8,10.
REQ-035 SHALL cover: start pulsed during RUN -> no counter restart; output sequence unchanged.

Source files
------------

// File: rtl/decimacao_pkg.sv
// Shared constants, FSM encoding and output-register payload for the 2x decimator.
package decimacao_pkg;

    localparam int unsigned IMG_W_DEF = 160;
    localparam int unsigned IMG_H_DEF = 120;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned PAIR_W    = PIX_W + 1;
    localparam int unsigned QUAD_W    = PIX_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [PIX_W-1:0] pixel;
    } out_reg_t;

    // Index width that stays legal for a depth of one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linha_buffer.sv
// Single-line store of horizontal pair sums: one write port, one asynchronous read port.
module linha_buffer
    import decimacao_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = PAIR_W,
    localparam int unsigned AW    = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/decimacao_2x.sv
// 2x raster downscaler: keeps the even/even sample, or with DECIMACAO_MEDIA_EN
// defined outputs the truncated 2x2 block average using linha_buffer.
module decimacao_2x
    import decimacao_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned COL_W = clog2_min1(IMG_W);
    localparam int unsigned ROW_W = clog2_min1(IMG_H);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    out_reg_t         out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             col_last_c;
    logic             last_c;
    logic             load_c;
    logic [PIX_W-1:0] load_pix_c;

    assign in_ready_c = (state_q == ST_RUN) && (!out_q.valid || out_ready);
    assign accept_c   = in_valid && in_ready_c;
    assign col_last_c = (col_q == COL_W'(IMG_W - 1));
    assign last_c     = col_last_c && (row_q == ROW_W'(IMG_H - 1));

`ifdef DECIMACAO_MEDIA_EN
    localparam int unsigned BUF_D  = IMG_W / 2;
    localparam int unsigned BUF_AW = clog2_min1(BUF_D);

    logic [PIX_W-1:0]  pix_even_q, pix_even_d;
    logic [PAIR_W-1:0] pair_sum_c;
    logic [PAIR_W-1:0] buf_rd_c;
    logic [QUAD_W-1:0] quad_sum_c;
    logic [BUF_AW-1:0] buf_addr_c;
    logic              buf_we_c;

    // Even rows park pair sums; odd rows complete the 2x2 sum on the odd column.
    assign pair_sum_c = PAIR_W'(pix_even_q) + PAIR_W'(in_pixel);
    assign quad_sum_c = QUAD_W'(buf_rd_c) + QUAD_W'(pair_sum_c);
    assign buf_addr_c = BUF_AW'(col_q >> 1);
    assign buf_we_c   = accept_c && !row_q[0] && col_q[0];
    assign load_c     = accept_c && row_q[0] && col_q[0];
    assign load_pix_c = PIX_W'(quad_sum_c >> 2);
    assign pix_even_d = (accept_c && !col_q[0]) ? in_pixel : pix_even_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_even_q <= '0;
        end else begin
            pix_even_q <= pix_even_d;
        end
    end

    linha_buffer #(
        .DEPTH  (BUF_D),
        .DATA_W (PAIR_W)
    ) u_linha_buffer (
        .clk       (clk),
        .wr_en_i   (buf_we_c),
        .wr_addr_i (buf_addr_c),
        .wr_data_i (pair_sum_c),
        .rd_addr_i (buf_addr_c),
        .rd_data_o (buf_rd_c)
    );
`else
    assign load_c     = accept_c && !row_q[0] && !col_q[0];
    assign load_pix_c = in_pixel;
`endif

    // State, counters, output register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        out_d   = out_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    if (col_last_c) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_q.valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reload in the same cycle as a consume keeps the register full.
        if (load_c) begin
            out_d.valid = 1'b1;
            out_d.pixel = load_pix_c;
        end else if (out_ready) begin
            out_d.valid = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign in_ready  = in_ready_c;
    assign out_pixel = out_q.pixel;
    assign out_valid = out_q.valid;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decimacao_2x.sv
// Table-driven scoreboard bench for decimacao_2x on a 4x4 frame; follows DECIMACAO_MEDIA_EN.
module tb_decimacao_2x;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;
    localparam int unsigned N = W * H;
`ifdef DECIMACAO_MEDIA_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [7:0] in_pixel, out_pixel;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    decimacao_2x #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [1:0]      kind;
        logic [1:0]      rdy;
        logic            gaps;
        logic            spulse;
        logic [3:0][7:0] ed;
        logic [3:0][7:0] ea;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'd255;
            2:       return 8'(255 - i);
            default: return 8'(17 * i);
        endcase
    endfunction

    function automatic vec_t mk(input int kind, input int rdy, input int gaps, input int sp,
                                input int d0, input int d1, input int d2, input int d3,
                                input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v.kind = 2'(kind); v.rdy = 2'(rdy); v.gaps = 1'(gaps); v.spulse = 1'(sp);
        v.ed[0] = 8'(d0); v.ed[1] = 8'(d1); v.ed[2] = 8'(d2); v.ed[3] = 8'(d3);
        v.ea[0] = 8'(a0); v.ea[1] = 8'(a1); v.ea[2] = 8'(a2); v.ea[3] = 8'(a3);
        return v;
    endfunction

    // Drives one frame; rdy: 0 always ready, 1 random, 2 one 5-cycle stall on first output.
    task automatic run_frame(input vec_t v, input int id);
        int i = 0, k = 0, outs = 0, dones = 0, cyc = 0, stall = 0;
        bit stall_used = 1'b0, hold_chk = 1'b0;
        logic [7:0] held = '0;
        int r, c;
        exp_q.delete();
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (dones == 0 && cyc < 400) begin
            in_valid = (i < N) && (!v.gaps || $urandom_range(0, 2) != 0);
            in_pixel = pix(int'(v.kind), (i < N) ? i : 0);
            start    = v.spulse && i >= 3 && i < 6;
            if (v.rdy == 2'd2 && !stall_used && out_valid) begin
                stall = 5;
                stall_used = 1'b1;
            end
            case (v.rdy)
                2'd1:    out_ready = 1'($urandom_range(0, 1));
                2'd2:    out_ready = (stall == 0);
                default: out_ready = 1'b1;
            endcase
            if (stall > 0) stall--;
            @(negedge clk);
            if (hold_chk) begin
                chk($sformatf("f%0d_hold_valid", id), 32'(out_valid), 32'd1);
                chk($sformatf("f%0d_hold_pixel", id), 32'(out_pixel), 32'(held));
            end
            if (v.rdy == 2'd2 && out_valid && !out_ready)
                chk($sformatf("f%0d_stall_in_ready", id), 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                outs++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("f%0d_unexpected_out", id), 32'(out_pixel), 32'hFFFF);
                end else begin
                    chk($sformatf("f%0d_out%0d", id, outs), 32'(out_pixel), 32'(exp_q.pop_front()));
                end
            end
            hold_chk = out_valid && !out_ready;
            held = out_pixel;
            if (in_valid && in_ready) begin
                r = i / W;
                c = i % W;
                if (AVG ? (r % 2 == 1 && c % 2 == 1) : (r % 2 == 0 && c % 2 == 0)) begin
                    exp_q.push_back(AVG ? v.ea[k] : v.ed[k]);
                    k++;
                end
                i++;
            end
            if (done) dones++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        chk($sformatf("f%0d_no_timeout", id), 32'(cyc < 400), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk($sformatf("f%0d_done_pulses", id), 32'(dones), 32'd1);
        chk($sformatf("f%0d_out_count", id), 32'(outs), 32'd4);
        chk($sformatf("f%0d_queue_left", id), 32'(exp_q.size()), 32'd0);
        chk($sformatf("f%0d_busy_after", id), 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc, i;
        tbl[0] = mk(0, 0, 0, 0,   0,   2,   8,  10,    2,   4,  10,  12);
        tbl[1] = mk(1, 0, 0, 0, 255, 255, 255, 255,  255, 255, 255, 255);
        tbl[2] = mk(2, 1, 1, 0, 255, 253, 247, 245,  252, 250, 244, 242);
        tbl[3] = mk(3, 1, 1, 0,   0,  34, 136, 170,   42,  76, 178, 212);
        tbl[4] = mk(0, 2, 0, 0,   0,   2,   8,  10,    2,   4,  10,  12);
        tbl[5] = mk(0, 0, 0, 1,   0,   2,   8,  10,    2,   4,  10,  12);
        tbl[6] = mk(2, 2, 1, 0, 255, 253, 247, 245,  252, 250, 244, 242);

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        @(negedge clk) reset = 1'b0;

        for (int t = 0; t < 7; t++) run_frame(tbl[t], t);

        // Reset after six accepts, then confirm nothing resumes without start.
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        acc = 0; cyc = 0; i = 0;
        while (acc < 6 && cyc < 100) begin
            in_valid = 1'b1;
            in_pixel = pix(0, i);
            @(negedge clk);
            if (in_valid && in_ready) begin acc++; i++; end
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_accepts", 32'(acc), 32'd6);
        chk("pre_reset_pix", 32'(out_pixel), 32'd2);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_pixel", 32'(out_pixel), 32'd0);
        chk("async_busy",      32'(busy),      32'd0);
        chk("async_done",      32'(done),      32'd0);
        chk("async_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_reset_in_ready", 32'(in_ready), 32'd0);
            chk("post_reset_busy",     32'(busy),     32'd0);
        end
        in_valid = 1'b0;
        run_frame(tbl[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
